ocp_bus_arbiter: RTL
====================

Name: ocp_bus_arbiter

Overview:
- Shares one 8-bit command/response target bus between two requesters, e.g. the UART transaction master plus a second master such as a debug or DMA port.
- Command encoding: MCmd 001=WR, 010=RD. Response encoding: SResp 01=DVA, 1x=ERR.
- Arbitration is round-robin. At most one read is outstanding on the target side, and the read response is routed back to the master that issued it.
- A response watchdog returns ERR to the owner if a read response never arrives.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 1024, cycles to wait for a read response before a local ERR (legal range 2..65535).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m0_MCmd  in  3  master 0 command.
- m0_MAddr  in  AW  master 0 address.
- m0_MData  in  DW  master 0 write data.
- m0_SCmdAccept  out  1  command accepted to master 0.
- m0_SData  out  DW  read data to master 0.
- m0_SResp  out  2  response to master 0.
- m1_MCmd, m1_MAddr, m1_MData, m1_SCmdAccept, m1_SData, m1_SResp: same as master 0, for master 1.
- s_MCmd  out  3  command to target.
- s_MAddr  out  AW  address to target.
- s_MData  out  DW  write data to target.
- s_SCmdAccept  in  1  target accept.
- s_SData  in  DW  target read data.
- s_SResp  in  2  target response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE, owner=0, last_grant=1 (so master 0 wins the first tie), timer=0.
  - All outputs 0.
  - An in-flight read is abandoned; no response is generated.
- States: IDLE, GRANT, WAIT_RESP.
- IDLE:
  - A master is requesting when mX_MCmd != 000.
  - With one requester, grant it. With both, grant the one that is not last_grant.
  - Register owner and go to GRANT on the next edge. Arbitration latency is 1 cycle.
  - Slave outputs are 0 in IDLE.
- GRANT:
  - s_MCmd/s_MAddr/s_MData are driven combinationally from the owner's inputs.
  - owner's SCmdAccept equals s_SCmdAccept combinationally. The non-owner's SCmdAccept is 0.
  - On s_SCmdAccept with MCmd=WR: last_grant=owner, then go to IDLE. Writes are posted and produce no response.
  - On s_SCmdAccept with MCmd=RD: last_grant=owner, timer cleared, then go to WAIT_RESP.
  - If the owner's MCmd is not 001 or 010 (illegal or reserved):
    - it is not forwarded (s_MCmd=000);
    - the owner's SCmdAccept pulses for 1 cycle locally;
    - last_grant=owner, then go to IDLE.
  - If the owner's MCmd drops to 000 before accept (protocol violation): go to IDLE, last_grant unchanged.
- WAIT_RESP:
  - s_MCmd=000 and no new command is granted.
  - timer increments every cycle.
  - If s_SResp != 00: register s_SResp/s_SData onto the owner's SResp/SData for exactly 1 cycle (1-cycle response latency), then go to IDLE.
  - Else if timer == TIMEOUT-1: drive owner SResp=11 and SData=0 for 1 cycle, then go to IDLE.
  - If the slave response and timer expiry land in the same cycle, the slave response wins.
- Response outputs:
  - mX_SResp/mX_SData are registered and are 0 in every cycle that does not carry a response.
  - The non-owner never sees a response.
- Stray target responses: s_SResp != 00 while in IDLE or GRANT (e.g. a late response after a timeout) is discarded, with no output change.
- Throughput: a back-to-back request from the same master is re-arbitrated in IDLE. Minimum spacing is 2 cycles per command, so a waiting master gets the grant next.

Test Plan:
- Single write: m0 drives MCmd=001, MAddr=0x12, MData=0x5A; target accepts 1 cycle after the grant -> s_MCmd=001, s_MAddr=0x12 in the GRANT cycle; m0_SCmdAccept=1 in that cycle; m0_SResp stays 00; busy returns to 0.
- Read routing: m1 issues RD to 0x40; target returns SResp=01, SData=0xC3 after 5 cycles -> m1_SResp=01 and m1_SData=0xC3 for exactly 1 cycle, one cycle after s_SResp; m0 outputs stay 0.
- Round-robin: both masters hold WR continuously -> grants alternate m0, m1, m0, m1; neither master gets two consecutive grants.
- Timeout: m0 issues RD with TIMEOUT=16 and the target never responds -> m0_SResp=11, SData=0x00 for 1 cycle, 16 cycles after accept. A later s_SResp=01 is ignored. m1's pending WR is then granted.
- Boundary/simultaneous: s_SResp=01 arrives in the cycle the timer reaches TIMEOUT-1 -> the slave data is delivered, not ERR. An illegal MCmd=011 from m0 -> 1-cycle local accept, s_MCmd stays 000.
- Reset mid-read: assert reset during WAIT_RESP -> all outputs go to 0 asynchronously. After release, no response is delivered and master 0 wins the first tie.

Source files
------------

// File: rtl/ocp_bus_arbiter.sv
// ocp_bus_arbiter: round-robin arbiter sharing one OCP target between two masters
module ocp_bus_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    m0_MCmd,
   input  logic [AW-1:0] m0_MAddr,
   input  logic [DW-1:0] m0_MData,
   output logic          m0_SCmdAccept,
   output logic [DW-1:0] m0_SData,
   output logic [1:0]    m0_SResp,
   input  logic [2:0]    m1_MCmd,
   input  logic [AW-1:0] m1_MAddr,
   input  logic [DW-1:0] m1_MData,
   output logic          m1_SCmdAccept,
   output logic [DW-1:0] m1_SData,
   output logic [1:0]    m1_SResp,
   output logic [2:0]    s_MCmd,
   output logic [AW-1:0] s_MAddr,
   output logic [DW-1:0] s_MData,
   input  logic          s_SCmdAccept,
   input  logic [DW-1:0] s_SData,
   input  logic [1:0]    s_SResp,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESP} state_t;
   localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
   state_t        state, state_nx;
   logic          owner, owner_nx, last_grant, last_grant_nx, accept;
   logic [15:0]   timer, timer_nx;
   logic [1:0]    resp_nx;
   logic [DW-1:0] data_nx;
   logic [2:0]    cmd;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          legal;
   assign cmd           = owner ? m1_MCmd : m0_MCmd;
   assign addr          = owner ? m1_MAddr : m0_MAddr;
   assign data          = owner ? m1_MData : m0_MData;
   assign legal         = (cmd == 3'b001) || (cmd == 3'b010);
   assign m0_SCmdAccept = accept & ~owner;
   assign m1_SCmdAccept = accept & owner;
   assign busy          = state != IDLE;
   // next-state, target-side drive and response selection
   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      last_grant_nx = last_grant;
      timer_nx      = timer;
      accept        = 1'b0;
      resp_nx       = 2'b00;
      data_nx       = '0;
      s_MCmd        = 3'b000;
      s_MAddr       = '0;
      s_MData       = '0;
      case (state)
         IDLE: if (|m0_MCmd || |m1_MCmd) begin
            owner_nx = |m1_MCmd && (~|m0_MCmd || !last_grant);
            state_nx = GRANT;
         end
         GRANT: begin
            s_MCmd  = legal ? cmd : 3'b000;
            s_MAddr = addr;
            s_MData = data;
            if (cmd == 3'b000) state_nx = IDLE;
            else if (!legal) begin
               accept        = 1'b1;
               last_grant_nx = owner;
               state_nx      = IDLE;
            end else if (s_SCmdAccept) begin
               accept        = 1'b1;
               last_grant_nx = owner;
               timer_nx      = '0;
               state_nx      = (cmd == 3'b010) ? WAIT_RESP : IDLE;
            end
         end
         WAIT_RESP: begin
            timer_nx = timer + 16'd1;
            if (s_SResp != 2'b00) begin
               resp_nx  = s_SResp;
               data_nx  = s_SData;
               state_nx = IDLE;
            end else if (timer == TLAST) begin
               resp_nx  = 2'b11;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   // state, arbitration history and one-cycle registered responses to the owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         timer      <= '0;
         m0_SResp   <= 2'b00;
         m0_SData   <= '0;
         m1_SResp   <= 2'b00;
         m1_SData   <= '0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         last_grant <= last_grant_nx;
         timer      <= timer_nx;
         m0_SResp   <= owner ? 2'b00 : resp_nx;
         m0_SData   <= owner ? '0 : data_nx;
         m1_SResp   <= owner ? resp_nx : 2'b00;
         m1_SData   <= owner ? data_nx : '0;
      end
   end
endmodule
